eth_mdio_master: RTL and testbench

Memory-mapped Clause-22 MDIO management master for the RGMII Ethernet subsystem. It sits directly downstream of the AXI-to-memory bridge, which supplies the req/we/addr/be/wdata strobes, and drives the PHY's MDC/MDIO pins. It serialises one PHY register read or write per command, exposes busy, done, error and read data through a status word, and pulses an interrupt on completion.

---
 rtl/eth_mdio_master.sv | 178 +++++++++++++++++
 tb/tb_eth_mdio_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO management master: memory-mapped CMD/STATUS words, one PHY
// register read or write per command, completion interrupt.
module eth_mdio_master #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MDC_DIV    = 25
) (
  input  logic                    msoc_clk,
  input  logic                    rst_int,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [4:0]              addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    phy_mdc_o,
  input  logic                    phy_mdio_i,
  output logic                    phy_mdio_o,
  output logic                    phy_mdio_oe_o,
  output logic                    mdio_irq_o
);

  localparam int unsigned PW         = $clog2(MDC_DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(MDC_DIV - 1);
  localparam logic [5:0]  BIT_LAST   = 6'd63;
  localparam logic [5:0]  BIT_PRE_TA = 6'd45;
  localparam logic [5:0]  BIT_DATA0  = 6'd48;
  localparam logic [1:0]  OP_WRITE   = 2'b01;
  localparam logic [1:0]  OP_READ    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINISH
  } state_e;

  state_e                  state_q;
  logic [PW-1:0]           phase_q;
  logic [5:0]              bit_q;
  logic [63:0]             frame_q;
  logic [15:0]             cap_q;
  logic                    is_read_q;
  logic [31:0]             cmd_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [15:0]             rd_data_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    mdc_q;
  logic                    mdio_q;
  logic                    oe_q;
  logic                    irq_q;

  logic                    cmd_wr_c;
  logic                    op_ok_c;
  logic [1:0]              op_c;
  logic [63:0]             frame_c;
  logic [31:0]             status_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;
  logic                    unused_c;

  // Command decode, outgoing frame image and bus read mux
  always_comb begin
    op_c     = wdata_i[11:10];
    op_ok_c  = (op_c == OP_WRITE) || (op_c == OP_READ);
    cmd_wr_c = req_i && we_i && (addr_i[4:3] == 2'd0) && (be_i[3:0] == 4'hF) && !busy_q;
    frame_c  = {32'hFFFF_FFFF, 2'b01, op_c, wdata_i[4:0], wdata_i[9:5], 2'b10, wdata_i[31:16]};
    if (op_c == OP_READ) begin
      // TA and DATA are released to the PHY; drive idle-high placeholders
      frame_c[17:0] = {2'b11, 16'hFFFF};
    end
    status_c = {rd_data_q, 13'd0, err_q, done_q, busy_q};
    case (addr_i[4:3])
      2'd0:    rd_word_c = DATA_WIDTH'(cmd_q);
      2'd1:    rd_word_c = DATA_WIDTH'(status_c);
      default: rd_word_c = '0;
    endcase
  end

  assign unused_c = ^{addr_i[2:0], be_i, wdata_i};

  assign rdata_o       = rdata_q;
  assign phy_mdc_o     = mdc_q;
  assign phy_mdio_o    = mdio_q;
  assign phy_mdio_oe_o = oe_q;
  assign mdio_irq_o    = irq_q;

  always_ff @(posedge msoc_clk or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      cap_q     <= '0;
      is_read_q <= 1'b0;
      cmd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rdata_q   <= '0;
      mdc_q     <= 1'b0;
      mdio_q    <= 1'b1;
      oe_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (req_i && !we_i) begin
        rdata_q <= rd_word_c;
      end

      case (state_q)
        ST_IDLE: begin
          mdc_q <= 1'b0;
          oe_q  <= 1'b0;
          if (cmd_wr_c) begin
            if (op_ok_c) begin
              cmd_q     <= wdata_i[31:0];
              frame_q   <= frame_c;
              is_read_q <= (op_c == OP_READ);
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              err_q     <= 1'b0;
              mdio_q    <= frame_c[63];
              oe_q      <= 1'b1;
              phase_q   <= '0;
              bit_q     <= '0;
              state_q   <= ST_SHIFT;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b0;
            end
          end
        end

        ST_SHIFT: begin
          if (phase_q == PHASE_LAST) begin
            phase_q <= '0;
            if (!mdc_q) begin
              mdc_q <= 1'b1;
              if (is_read_q && (bit_q >= BIT_DATA0)) begin
                cap_q <= {cap_q[14:0], phy_mdio_i};
              end
            end else if (bit_q == BIT_LAST) begin
              mdc_q   <= 1'b0;
              oe_q    <= 1'b0;
              mdio_q  <= 1'b1;
              irq_q   <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              // MDC falling edge: present the next frame bit
              mdc_q   <= 1'b0;
              bit_q   <= bit_q + 6'd1;
              frame_q <= {frame_q[62:0], 1'b1};
              mdio_q  <= frame_q[62];
              if (is_read_q && (bit_q == BIT_PRE_TA)) begin
                oe_q <= 1'b0;
              end
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end

        ST_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (is_read_q) begin
            rd_data_q <= cap_q;
          end
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mdio_master.sv
// Self-checking bench for eth_mdio_master: randomized MDIO write/read frames
// checked against a frame-level reference model and a simple PHY responder.
module tb_eth_mdio_master;

  localparam int DW    = 64;
  localparam int D     = 2;
  localparam int LIMIT = 128 * D + 12;
  localparam logic [63:0] RD_MASK = 64'hFFFF_FFFF_FFFC_0000;

  logic          msoc_clk;
  logic          rst_int;
  logic          req_i;
  logic          we_i;
  logic [4:0]    addr_i;
  logic [DW/8-1:0] be_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o;
  logic          phy_mdc_o;
  logic          phy_mdio_i;
  logic          phy_mdio_o;
  logic          phy_mdio_oe_o;
  logic          mdio_irq_o;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [15:0]   model_rd;
  logic [31:0]   model_cmd;

  eth_mdio_master #(.DATA_WIDTH(DW), .MDC_DIV(D)) dut (
    .msoc_clk      (msoc_clk),
    .rst_int       (rst_int),
    .req_i         (req_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .rdata_o       (rdata_o),
    .phy_mdc_o     (phy_mdc_o),
    .phy_mdio_i    (phy_mdio_i),
    .phy_mdio_o    (phy_mdio_o),
    .phy_mdio_oe_o (phy_mdio_oe_o),
    .mdio_irq_o    (mdio_irq_o)
  );

  initial msoc_clk = 1'b0;
  always #5 msoc_clk = ~msoc_clk;

  // Reference frame: preamble, ST, OP, PHYAD, REGAD, TA, DATA, sent MSB first
  function automatic logic [63:0] exp_frame(input logic [31:0] cmd);
    logic [1:0]  ta;
    logic [15:0] dat;
    if (cmd[11:10] == 2'b10) begin
      ta  = 2'b11;
      dat = 16'hFFFF;
    end else begin
      ta  = 2'b10;
      dat = cmd[31:16];
    end
    return {32'hFFFF_FFFF, 2'b01, cmd[11:10], cmd[4:0], cmd[9:5], ta, dat};
  endfunction

  function automatic logic [63:0] status_word(input logic [15:0] rd, input logic err,
                                              input logic done, input logic busy);
    return 64'({rd, 13'd0, err, done, busy});
  endfunction

  function automatic logic [31:0] make_cmd(input logic [15:0] dat, input logic [1:0] op);
    logic [31:0] r;
    r = $urandom;
    return {dat, r[15:12], op, r[9:5], r[4:0]};
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [7:0] be, input logic [63:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; be_i = be; wdata_i = d;
    @(posedge msoc_clk); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [63:0] d);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(posedge msoc_clk); #1;
    req_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic idle_activity(input int cycles, output int act);
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge msoc_clk); #1;
      if (phy_mdc_o || phy_mdio_oe_o || mdio_irq_o) act++;
    end
  endtask

  // Issues a CMD write and observes one frame cycle by cycle, acting as the PHY
  task automatic run_frame(input logic [31:0] cmd, input logic [15:0] phy_data,
                           input int inject_n, input logic [31:0] inject_cmd, input int rd_n,
                           output logic [63:0] obs_bits, output logic [63:0] obs_oe,
                           output int rise_bad, output int nrises,
                           output int irq_n, output int irq_cnt,
                           output logic [2:0] first_pins, output logic [2:0] fin_pins,
                           output logic [63:0] rd1, output logic [63:0] rd2);
    logic prev_mdc;
    logic rd_mode;
    obs_bits = '0; obs_oe = '0; rise_bad = 0; nrises = 0; irq_n = 0; irq_cnt = 0;
    fin_pins = '0; rd1 = '0; rd2 = '0;
    rd_mode = (cmd[11:10] == 2'b10);
    phy_mdio_i = 1'b1;
    bus_write(5'h00, 8'hFF, 64'(cmd));
    first_pins = {phy_mdc_o, phy_mdio_o, phy_mdio_oe_o};
    prev_mdc = 1'b0;
    for (int n = 1; n <= LIMIT; n++) begin
      if (n > 1) begin
        @(posedge msoc_clk); #1;
      end
      if (phy_mdc_o && !prev_mdc) begin
        if (nrises < 64) begin
          obs_bits[6'(63 - nrises)] = phy_mdio_o;
          obs_oe[6'(63 - nrises)]   = phy_mdio_oe_o;
          if (n != D + 1 + 2 * D * nrises) rise_bad++;
          if (rd_mode && nrises >= 47 && nrises <= 62) phy_mdio_i = phy_data[4'(62 - nrises)];
          else if (nrises == 63) phy_mdio_i = 1'b1;
        end
        nrises++;
      end
      prev_mdc = phy_mdc_o;
      if (mdio_irq_o) begin
        if (irq_cnt == 0) begin
          irq_n    = n;
          fin_pins = {phy_mdc_o, phy_mdio_o, phy_mdio_oe_o};
        end
        irq_cnt++;
      end
      if (rd_n > 0 && n == rd_n + 1) rd1 = rdata_o;
      if (rd_n > 0 && n == rd_n + 2) begin
        rd2 = rdata_o;
        req_i = 1'b0;
      end
      if (rd_n > 0 && n == rd_n) begin
        req_i = 1'b1; we_i = 1'b0; addr_i = 5'h08;
      end
      if (inject_n > 0 && n == inject_n) begin
        req_i = 1'b1; we_i = 1'b1; addr_i = 5'h00; be_i = 8'hFF; wdata_i = 64'(inject_cmd);
      end
      if (inject_n > 0 && n == inject_n + 1) begin
        req_i = 1'b0; we_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic [31:0] cmd;
    int act;
    #1;
    n_checks++; if ({phy_mdc_o, phy_mdio_o, phy_mdio_oe_o, mdio_irq_o} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_pins: got %b want 0100", {phy_mdc_o, phy_mdio_o, phy_mdio_oe_o, mdio_irq_o}); end
    n_checks++; if (rdata_o !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    repeat (3) @(posedge msoc_clk);
    #1; rst_int = 1'b0;
    @(posedge msoc_clk); #1;
    bus_read(5'h08, d);
    n_checks++; if (d !== 64'd0) begin
      n_fail++; $display("FAIL reset_status: got %h want 0", d); end
    // Abandon a frame mid-SHIFT with an asynchronous reset
    cmd = make_cmd(16'($urandom), 2'b01);
    bus_write(5'h00, 8'hFF, 64'(cmd));
    repeat (30) @(posedge msoc_clk);
    #3; rst_int = 1'b1;
    #1;
    n_checks++; if ({phy_mdc_o, phy_mdio_o, phy_mdio_oe_o, mdio_irq_o} !== 4'b0100) begin
      n_fail++; $display("FAIL midreset_pins: got %b want 0100", {phy_mdc_o, phy_mdio_o, phy_mdio_oe_o, mdio_irq_o}); end
    @(posedge msoc_clk); #1;
    rst_int = 1'b0;
    idle_activity(300, act);
    n_checks++; if (act !== 0) begin
      n_fail++; $display("FAIL midreset_quiet: got %0d active cycles want 0", act); end
    bus_read(5'h08, d);
    n_checks++; if (d !== 64'd0) begin
      n_fail++; $display("FAIL midreset_status: got %h want 0", d); end
    model_rd  = 16'h0;
    model_cmd = 32'h0;
  endtask

  task automatic test_write_frame();
    logic [31:0] cmd;
    logic [63:0] bits, oe, rd1, rd2, d;
    logic [2:0]  fp, lp;
    int rb, nr, in, ic;
    for (int t = 0; t < 3; t++) begin
      cmd = (t == 0) ? 32'hA5C3_0481 : make_cmd(16'($urandom), 2'b01);
      run_frame(cmd, 16'h0, 0, 32'h0, 128 * D + 1, bits, oe, rb, nr, in, ic, fp, lp, rd1, rd2);
      n_checks++; if (bits !== exp_frame(cmd)) begin
        n_fail++; $display("FAIL wr_bits[%0d]: got %h want %h", t, bits, exp_frame(cmd)); end
      n_checks++; if (oe !== 64'hFFFF_FFFF_FFFF_FFFF) begin
        n_fail++; $display("FAIL wr_oe[%0d]: got %h want all ones", t, oe); end
      n_checks++; if (rb !== 0 || nr !== 64) begin
        n_fail++; $display("FAIL wr_mdc_timing[%0d]: got %0d late rises of %0d want 0 of 64", t, rb, nr); end
      n_checks++; if (in !== 128 * D + 1 || ic !== 1) begin
        n_fail++; $display("FAIL wr_irq[%0d]: got cycle %0d count %0d want cycle %0d count 1", t, in, ic, 128 * D + 1); end
      n_checks++; if (fp !== 3'b011 || lp !== 3'b010) begin
        n_fail++; $display("FAIL wr_pins[%0d]: got start %b finish %b want 011 010", t, fp, lp); end
      n_checks++; if (rd1 !== status_word(model_rd, 1'b0, 1'b0, 1'b1)) begin
        n_fail++; $display("FAIL wr_status_finish[%0d]: got %h want %h", t, rd1, status_word(model_rd, 1'b0, 1'b0, 1'b1)); end
      n_checks++; if (rd2 !== status_word(model_rd, 1'b0, 1'b1, 1'b0)) begin
        n_fail++; $display("FAIL wr_status_done[%0d]: got %h want %h", t, rd2, status_word(model_rd, 1'b0, 1'b1, 1'b0)); end
      model_cmd = cmd;
      bus_read(5'h00, d);
      n_checks++; if (d !== 64'(model_cmd)) begin
        n_fail++; $display("FAIL wr_cmd_readback[%0d]: got %h want %h", t, d, 64'(model_cmd)); end
    end
  endtask

  task automatic test_invalid();
    logic [63:0] d;
    logic [31:0] cmd;
    int act;
    for (int t = 0; t < 2; t++) begin
      cmd = make_cmd(16'($urandom), (t == 0) ? 2'b11 : 2'b00);
      bus_write(5'h00, 8'hFF, 64'(cmd));
      idle_activity(4 * D + 2, act);
      n_checks++; if (act !== 0) begin
        n_fail++; $display("FAIL inv_quiet[%0d]: got %0d active cycles want 0", t, act); end
      bus_read(5'h08, d);
      n_checks++; if (d !== status_word(model_rd, 1'b1, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL inv_status[%0d]: got %h want %h", t, d, status_word(model_rd, 1'b1, 1'b0, 1'b0)); end
    end
    cmd = make_cmd(16'($urandom), 2'b01);
    bus_write(5'h00, 8'h03, 64'(cmd));
    idle_activity(4 * D + 2, act);
    n_checks++; if (act !== 0) begin
      n_fail++; $display("FAIL partial_quiet: got %0d active cycles want 0", act); end
    bus_read(5'h08, d);
    n_checks++; if (d !== status_word(model_rd, 1'b1, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL partial_status: got %h want %h", d, status_word(model_rd, 1'b1, 1'b0, 1'b0)); end
    bus_read(5'h00, d);
    n_checks++; if (d !== 64'(model_cmd)) begin
      n_fail++; $display("FAIL partial_cmd: got %h want %h", d, 64'(model_cmd)); end
  endtask

  task automatic test_read_frame();
    logic [31:0] cmd;
    logic [15:0] pd;
    logic [63:0] bits, oe, rd1, rd2;
    logic [2:0]  fp, lp;
    int rb, nr, in, ic;
    for (int t = 0; t < 3; t++) begin
      pd  = (t == 0) ? 16'h796D : 16'($urandom);
      cmd = make_cmd(16'($urandom), 2'b10);
      run_frame(cmd, pd, 0, 32'h0, 128 * D + 1, bits, oe, rb, nr, in, ic, fp, lp, rd1, rd2);
      n_checks++; if ((bits & RD_MASK) !== (exp_frame(cmd) & RD_MASK)) begin
        n_fail++; $display("FAIL rd_bits[%0d]: got %h want %h", t, bits & RD_MASK, exp_frame(cmd) & RD_MASK); end
      n_checks++; if (oe !== RD_MASK) begin
        n_fail++; $display("FAIL rd_oe[%0d]: got %h want %h", t, oe, RD_MASK); end
      n_checks++; if (rb !== 0 || nr !== 64 || in !== 128 * D + 1 || ic !== 1) begin
        n_fail++; $display("FAIL rd_timing[%0d]: got late %0d rises %0d irq@%0d x%0d", t, rb, nr, in, ic); end
      n_checks++; if (rd1 !== status_word(model_rd, 1'b0, 1'b0, 1'b1)) begin
        n_fail++; $display("FAIL rd_status_finish[%0d]: got %h want %h", t, rd1, status_word(model_rd, 1'b0, 1'b0, 1'b1)); end
      model_rd  = pd;
      model_cmd = cmd;
      n_checks++; if (rd2 !== status_word(model_rd, 1'b0, 1'b1, 1'b0)) begin
        n_fail++; $display("FAIL rd_status_done[%0d]: got %h want %h", t, rd2, status_word(model_rd, 1'b0, 1'b1, 1'b0)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cmd_a, cmd_b;
    logic [15:0] pd;
    logic [63:0] bits, oe, rd1, rd2, d;
    logic [2:0]  fp, lp;
    int rb, nr, in, ic;
    cmd_a = make_cmd(16'($urandom), 2'b01);
    cmd_b = make_cmd(16'($urandom), 2'b10);
    run_frame(cmd_a, 16'h0, 40, cmd_b, 0, bits, oe, rb, nr, in, ic, fp, lp, rd1, rd2);
    n_checks++; if (bits !== exp_frame(cmd_a) || nr !== 64 || ic !== 1) begin
      n_fail++; $display("FAIL busy_reject: got bits %h rises %0d irqs %0d want %h 64 1", bits, nr, ic, exp_frame(cmd_a)); end
    model_cmd = cmd_a;
    bus_read(5'h00, d);
    n_checks++; if (d !== 64'(model_cmd)) begin
      n_fail++; $display("FAIL busy_cmd: got %h want %h", d, 64'(model_cmd)); end
    // Next command back to back; a write landing in FINISH must be dropped
    pd    = 16'($urandom);
    cmd_a = make_cmd(16'($urandom), 2'b10);
    cmd_b = make_cmd(16'($urandom), 2'b01);
    run_frame(cmd_a, pd, 128 * D + 1, cmd_b, 0, bits, oe, rb, nr, in, ic, fp, lp, rd1, rd2);
    n_checks++; if (nr !== 64 || ic !== 1 || in !== 128 * D + 1) begin
      n_fail++; $display("FAIL finish_reject: got rises %0d irqs %0d irq@%0d want 64 1 %0d", nr, ic, in, 128 * D + 1); end
    model_cmd = cmd_a;
    model_rd  = pd;
    bus_read(5'h00, d);
    n_checks++; if (d !== 64'(model_cmd)) begin
      n_fail++; $display("FAIL finish_cmd: got %h want %h", d, 64'(model_cmd)); end
    bus_read(5'h08, d);
    n_checks++; if (d !== status_word(model_rd, 1'b0, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL finish_status: got %h want %h", d, status_word(model_rd, 1'b0, 1'b1, 1'b0)); end
  endtask

  task automatic test_bus_decode();
    logic [63:0] d;
    int act;
    bus_read(5'h10, d);
    n_checks++; if (d !== 64'd0) begin
      n_fail++; $display("FAIL unmapped_10: got %h want 0", d); end
    bus_read(5'h18, d);
    n_checks++; if (d !== 64'd0) begin
      n_fail++; $display("FAIL unmapped_18: got %h want 0", d); end
    bus_write(5'h08, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_write(5'h10, 8'hFF, 64'(make_cmd(16'($urandom), 2'b01)));
    idle_activity(4 * D + 2, act);
    n_checks++; if (act !== 0) begin
      n_fail++; $display("FAIL unmapped_write_quiet: got %0d active cycles want 0", act); end
    bus_read(5'h08, d);
    n_checks++; if (d !== status_word(model_rd, 1'b0, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL status_write_ignored: got %h want %h", d, status_word(model_rd, 1'b0, 1'b1, 1'b0)); end
    bus_read(5'h00, d);
    repeat (5) @(posedge msoc_clk);
    #1;
    n_checks++; if (rdata_o !== 64'(model_cmd)) begin
      n_fail++; $display("FAIL rdata_hold: got %h want %h", rdata_o, 64'(model_cmd)); end
  endtask

  initial begin
    rst_int    = 1'b1;
    req_i      = 1'b0;
    we_i       = 1'b0;
    addr_i     = '0;
    be_i       = '0;
    wdata_i    = '0;
    phy_mdio_i = 1'b1;
    model_rd   = '0;
    model_cmd  = '0;
    test_reset();
    test_write_frame();
    test_invalid();
    test_read_frame();
    test_back_to_back();
    test_bus_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
